// File: rtl/vga_pkg.sv
// Shared VGA timing constants, axis state type and segment-total helper.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  typedef enum logic [1:0] {
    AX_ACTIVE = 2'd0,
    AX_FRONT  = 2'd1,
    AX_SYNC   = 2'd2,
    AX_BACK   = 2'd3
  } axis_state_e;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK FSM.
// in_active and sync are registered from the next count, so they never skew against count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             in_active,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

  if (FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_seg
    $error("vga_axis_counter: porch and sync lengths must be nonzero");
  end
  if (TOTAL > (2 ** CNT_W)) begin : g_bad_width
    $error("vga_axis_counter: axis total does not fit in CNT_W bits");
  end

  axis_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_active_q, in_active_d;
  logic             sync_q, sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= AX_ACTIVE;
      count_q     <= '0;
      in_active_q <= 1'b1;
      sync_q      <= ~POL;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_active_q <= in_active_d;
      sync_q      <= sync_d;
    end
  end

  // Segment boundaries are tested against the next count so the state
  // lands in the same cycle the count crosses the boundary.
  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
    state_d = state_q;
    unique case (state_q)
      AX_ACTIVE: if (count_d == FP_START)   state_d = AX_FRONT;
      AX_FRONT:  if (count_d == SYNC_START) state_d = AX_SYNC;
      AX_SYNC:   if (count_d == BP_START)   state_d = AX_BACK;
      AX_BACK:   if (count_d == '0)         state_d = AX_ACTIVE;
      default:                              state_d = AX_ACTIVE;
    endcase
  end

  always_comb begin
    in_active_d = (state_d == AX_ACTIVE);
    sync_d      = (state_d == AX_SYNC) ? POL : ~POL;
  end

  assign count     = count_q;
  assign in_active = in_active_q;
  assign sync      = sync_q;
  assign wrap      = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal axis steps on ce, vertical on ce at line wrap.
// All state holds while ce=0; strobes are registered from the next position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             line_start,
  output logic             frame_start
);

  logic h_active, h_wrap;
  logic v_active, v_wrap;
  logic v_step;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  assign v_step = ce & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(ce),
    .count(col), .in_active(h_active), .sync(hsync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(v_step),
    .count(row), .in_active(v_active), .sync(vsync), .wrap(v_wrap)
  );

  // Next col is 0 exactly when this ce cycle wraps the line; likewise for (0,0).
  always_comb begin
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (ce) begin
      line_start_d  = h_wrap;
      frame_start_d = h_wrap & v_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Both terms are flops updated on the same edge, so de carries no skew.
  assign de          = h_active & v_active;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: small positive-polarity raster and default 640x480 raster driven by random ce,
// compared against a coordinate-level model with timing rules evaluated by arithmetic.
module tb_vga_timing_gen;

  localparam int A_HA = 8, A_HF = 2, A_HS = 2, A_HB = 2;
  localparam int A_VA = 4, A_VF = 1, A_VS = 1, A_VB = 1;
  localparam int A_HT = 14, A_VT = 7;
  localparam int B_HA = 640, B_HF = 16, B_HS = 96, B_HB = 48;
  localparam int B_VA = 480, B_VF = 10, B_VS = 2, B_VB = 33;
  localparam int B_HT = 800, B_VT = 525;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;

  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [3:0] col_a, row_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] col_b, row_b;

  int total = 0;
  int bad   = 0;
  int mc_a = 0, mr_a = 0, mc_b = 0, mr_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .col(col_a), .row(row_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen dut_b (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .col(col_b), .row(row_b), .line_start(ls_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sync_lvl(input int pos, input int start, input int len, input int pol);
    return (pos >= start && pos < start + len) ? pol : 1 - pol;
  endfunction

  task automatic check_all();
    chk("a_col", int'(col_a), mc_a);
    chk("a_row", int'(row_a), mr_a);
    chk("a_de", int'(de_a), int'(mc_a < A_HA && mr_a < A_VA));
    chk("a_hsync", int'(hs_a), sync_lvl(mc_a, A_HA + A_HF, A_HS, 1));
    chk("a_vsync", int'(vs_a), sync_lvl(mr_a, A_VA + A_VF, A_VS, 1));
    chk("a_line_start", int'(ls_a), int'(mc_a == 0));
    chk("a_frame_start", int'(fs_a), int'(mc_a == 0 && mr_a == 0));
    chk("b_col", int'(col_b), mc_b);
    chk("b_row", int'(row_b), mr_b);
    chk("b_de", int'(de_b), int'(mc_b < B_HA && mr_b < B_VA));
    chk("b_hsync", int'(hs_b), sync_lvl(mc_b, B_HA + B_HF, B_HS, 0));
    chk("b_vsync", int'(vs_b), sync_lvl(mr_b, B_VA + B_VF, B_VS, 0));
    chk("b_line_start", int'(ls_b), int'(mc_b == 0));
    chk("b_frame_start", int'(fs_b), int'(mc_b == 0 && mr_b == 0));
  endtask

  // One clk cycle with the given ce; model advances by one raster position per ce.
  task automatic tick(input bit c);
    ce = c;
    @(posedge clk);
    if (c && !rst) begin
      mc_a++;
      if (mc_a == A_HT) begin mc_a = 0; mr_a = (mr_a + 1) % A_VT; end
      mc_b++;
      if (mc_b == B_HT) begin mc_b = 0; mr_b = (mr_b + 1) % B_VT; end
    end
    #1 check_all();
  endtask

  task automatic model_reset();
    mc_a = 0; mr_a = 0; mc_b = 0; mr_b = 0;
  endtask

  initial begin
    // Reset applied and held across edges, ce both high and low.
    #1 rst = 1'b1;
    #1 model_reset();
    check_all();
    tick(1'b1);
    tick(1'b0);
    // Release between edges with ce=1: first pixel is (0,0), then col=1.
    #2 rst = 1'b0;
    #1 check_all();
    tick(1'b1);
    chk("b_col_after_release", int'(col_b), 1);
    chk("b_hsync_after_release", int'(hs_b), 1);
    chk("b_fs_after_release", int'(fs_b), 0);

    // Random ce around half the time.
    for (int i = 0; i < 400; i++) tick(1'($urandom_range(0, 1)));
    // Solid ce: many small frames and a couple of default lines.
    for (int i = 0; i < 1400; i++) tick(1'b1);
    // Sparse ce, roughly 1-in-4.
    for (int i = 0; i < 800; i++) tick(1'($urandom_range(0, 3) == 0));

    // Run default raster on to col 700, then hit reset between edges.
    for (int i = 0; i < 3000 && mc_b != 700; i++) tick(1'b1);
    chk("b_col_before_async_rst", int'(col_b), 700);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    tick(1'b1);
    #2 rst = 1'b0;
    #1 check_all();
    for (int i = 0; i < 1000; i++) tick(1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 300; i++) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, the successor to sync_pulse_gen. Per-axis porch and sync timing and sync polarity are configurable. A clock-enable input allows pixel-rate stepping from a faster clock. Outputs are registered data-enable, line/frame strobes and pixel coordinates that feed the pixel pipeline and the VGA_HSYNC/VGA_VSYNC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level
CNT_W, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel-domain clock
rst  in  1  asynchronous, active-high reset
ce  in  1  pixel step enable; all state advances only when ce=1
hsync  out  1  horizontal sync, polarity H_POL
vsync  out  1  vertical sync, polarity V_POL
de  out  1  1 while col<H_ACTIVE and row<V_ACTIVE
col  out  CNT_W  horizontal counter, 0..H_TOTAL-1
row  out  CNT_W  vertical counter, 0..V_TOTAL-1
line_start  out  1  one-ce-cycle pulse while col==0
frame_start  out  1  one-ce-cycle pulse while col==0 and row==0

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset is asynchronous and active-high. Reset values: col=0, row=0, de=1, line_start=1, frame_start=1, hsync=~H_POL, vsync=~V_POL.
- Each axis is a 4-state FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Horizontal transitions occur at counts H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC and wrap.
- On ce=1: col increments. When col==H_TOTAL-1, col wraps to 0 and row steps by 1. When row==V_TOTAL-1 at that same wrap, row wraps to 0.
- On ce=0: every output holds, including the pulses, which are qualified by ce externally.
- All outputs are flops. Each output is computed from the next counter values, so it is always consistent with the col/row presented in the same cycle (zero relative skew).
- hsync is asserted for H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC. vsync changes only together with the col wrap to 0.
- Row wrap and col wrap in the same ce cycle both take effect, so frame_start follows directly.
- Reset mid-frame returns immediately to the reset state; the first pixel after reset release is (0,0).
- Elaboration check: $error if any porch or sync parameter is 0, or if a total exceeds 2**CNT_W.

Decomposition:
- vga_pkg: default 640x480@60 timing constants, the axis state typedef (ACTIVE, FRONT, SYNC, BACK), and a function computing the total from the four segment lengths.
- Sub-module vga_axis_counter: parameters (ACTIVE, FP, SYNC, BP, POL, CNT_W); ports clk, rst, step, count, in_active, sync, wrap. Instantiated twice: horizontal with step=ce, vertical with step=ce & h_wrap.

Test Plan:
1. Reset held, then released with ce=1 -> col=0, row=0, de=1, frame_start=1; next cycle col=1, frame_start=0, hsync=1.
2. Default params, one full line -> hsync low exactly for col 656..751 (96 cycles), de low from col 640, line_start every 800 cycles.
3. Full frame -> vsync low for rows 490..491 (1600 ce cycles), frame_start period 420000 cycles, de high for 307200 cycles per frame.
4. ce toggled 1-of-4 -> counters and outputs advance only on ce cycles; frame period 1,680,000 clk cycles.
5. H_POL=1, V_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> hsync high at col 10..11, vsync high on row 5, H_TOTAL=14, V_TOTAL=7.
6. rst asserted asynchronously at col=700, row=300 -> outputs reach reset values before the next clk edge; restart at (0,0).
